wb_initiator: RTL and testbench
===============================

# wb_initiator

Wishbone classic initiator that turns a simple valid/ready request–response port into single Wishbone B4 classic cycles, with one transaction outstanding and a bus-timeout abort. It is the initiator counterpart of the controller's on-chip memories, which act as Wishbone responders. It lets a core wrapper or an in-fabric self-test engine drive `Memory` through the same `cyc/stb/we/addr/data/ack` bus the cores use.

## Interface

**Parameters**
- `ADDR_WIDTH`, 32: Wishbone address width.
- `DATA_WIDTH`, 32: Wishbone data width.
- `TIMEOUT_CYCLES`, 255: maximum wait cycles for `ack_i`. Value 0 disables the timeout. The counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset is asynchronous and active-low.
- `req_valid_i`, in, 1: request present.
- `req_ready_o`, out, 1: request accepted when this and `req_valid_i` are both high at a rising edge.
- `req_we_i`, in, 1: 1 = write, 0 = read.
- `req_addr_i`, in, ADDR_WIDTH: request address.
- `req_wdata_i`, in, DATA_WIDTH: write data.
- `rsp_valid_o`, out, 1: response present.
- `rsp_ready_i`, in, 1: response consumed when this and `rsp_valid_o` are both high at a rising edge.
- `rsp_rdata_o`, out, DATA_WIDTH: read data. It is 0 for writes and for errors.
- `rsp_err_o`, out, 1: the transaction timed out.
- `cyc_o`, out, 1: Wishbone cycle.
- `stb_o`, out, 1: Wishbone strobe.
- `we_o`, out, 1: Wishbone write enable.
- `addr_o`, out, ADDR_WIDTH: Wishbone address.
- `data_o`, out, DATA_WIDTH: Wishbone write data.
- `data_i`, in, DATA_WIDTH: Wishbone read data.
- `ack_i`, in, 1: Wishbone acknowledge.

## Operation

**Reset values.** All outputs are registered. While `rst_n` is low, all outputs are 0 except `req_ready_o`, which is 1. The FSM is in IDLE and the timeout counter is 0.

**FSM states and transitions:**
- **IDLE**
  - `req_ready_o` = 1.
  - On acceptance: latch `we`/`addr`/`wdata` into the bus registers, set `cyc_o` = `stb_o` = 1, set `req_ready_o` = 0, clear the counter, and go to BUS.
- **BUS**
  - `cyc_o`, `stb_o`, `we_o`, `addr_o` and `data_o` are held stable.
  - When `ack_i` = 1:
    - drop `cyc_o`/`stb_o`;
    - set `rsp_rdata_o` = `we_o` ? 0 : `data_i`;
    - set `rsp_err_o` = 0 and `rsp_valid_o` = 1;
    - go to RESP.
  - Otherwise, if `TIMEOUT_CYCLES` ≠ 0 and counter = `TIMEOUT_CYCLES`-1:
    - drop `cyc_o`/`stb_o`;
    - set `rsp_rdata_o` = 0, `rsp_err_o` = 1, `rsp_valid_o` = 1;
    - go to RESP.
  - Otherwise, increment the counter.
- **RESP**
  - `rsp_valid_o` and the response data/error are held stable until consumed.
  - On consumption: clear `rsp_valid_o`, set `req_ready_o` = 1, and go to IDLE.

**Rules and boundary conditions:**
- `we_o`, `addr_o` and `data_o` keep their last values outside BUS. Only `cyc_o`/`stb_o` qualify them.
- `ack_i` in IDLE or RESP is ignored: no state change and no response.
- If `ack_i` and the timeout condition occur in the same cycle, ack wins and `rsp_err_o` = 0.
- `req_valid_i` outside IDLE is ignored and not queued. The requester holds the request until `req_ready_o` is high.
- `cyc_o` and `stb_o` are always equal.
- When reset is asserted mid-BUS, `cyc_o`/`stb_o` drop immediately (asynchronously) and the transaction is lost with no response.

## Timing

- Request accepted at edge N: `cyc_o`/`stb_o` are high during cycle N+1.
- `ack_i` sampled high at edge M: `cyc_o` is low and `rsp_valid_o` is high during cycle M+1.
- Against a responder that acks in the first bus cycle, the minimum request-to-response latency is 2 cycles.
- With `rsp_ready_i` tied high, throughput is 1 transaction per 3 cycles (IDLE → BUS → RESP).
- Timeout: `cyc_o` is high for exactly `TIMEOUT_CYCLES` cycles. `rsp_valid_o` with `rsp_err_o` = 1 appears in the following cycle.
- No combinational path from any input to any output.

## Test plan

- **Reset.** Assert `rst_n` = 0 mid-BUS (`cyc_o` = 1).
  - Required: `cyc_o` = `stb_o` = `rsp_valid_o` = 0 and `req_ready_o` = 1 immediately.
  - After release, a new request completes normally.
- **Write then read against `Memory`.**
  - Write addr 0x0000_0010 with data 0xCAFE_F00D. Required: `rsp_valid_o` with `rsp_err_o` = 0 and `rsp_rdata_o` = 0.
  - Then read 0x0000_0010. Required: `rsp_rdata_o` = 0xCAFE_F00D.
- **Back-pressure.**
  - Hold `rsp_ready_i` = 0 for 10 cycles after a read returns 0x1234_5678.
  - Required: `rsp_valid_o`/`rsp_rdata_o` stay stable, `req_ready_o` = 0, and a new `req_valid_i` is ignored.
- **Timeout.** `TIMEOUT_CYCLES` = 8, `ack_i` tied 0.
  - Required: `cyc_o` high for exactly 8 cycles, then `rsp_err_o` = 1 and `rsp_rdata_o` = 0.
  - Repeat with `ack_i` on the 8th bus cycle carrying 0xA5A5_A5A5. Required: `rsp_err_o` = 0 and `rsp_rdata_o` = 0xA5A5_A5A5.
- **Spurious ack.** Pulse `ack_i` in IDLE and in RESP.
  - Required: no state change and no extra `rsp_valid_o`.
- **Random stress.** 1000 random read/write transactions against `Memory`, with random `rsp_ready_i` stalls, checked against a scoreboard.
  - Required: every read returns the last value written, every request gets exactly one response, and `cyc_o` equals `stb_o` on every cycle.

Source files
------------

// File: rtl/wb_initiator.sv
// Wishbone B4 classic initiator: turns a valid/ready request port into single
// bus cycles, one transaction outstanding, with an optional ack timeout.
module wb_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ack_i
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            addr_o      <= '0;
            data_o      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        we_o        <= req_we_i;
                        addr_o      <= req_addr_i;
                        data_o      <= req_wdata_i;
                        cyc_o       <= 1'b1;
                        stb_o       <= 1'b1;
                        req_ready_o <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= BUS;
                    end
                end
                BUS: begin
                    // ack takes priority over a timeout expiring on the same cycle
                    if (ack_i) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_rdata_o <= we_o ? '0 : data_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state_reg   <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST)) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state_reg   <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed and random checks of wb_initiator against a simple Wishbone memory
// responder whose ack can be delayed, disabled or forced.
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] addr_o, data_o, data_i;
    logic        ack_i;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem [0:255];
    logic        mem_en = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] force_data = '0;
    int          wait_target = 0;
    int          wait_cnt = 0;

    always #5 clk = ~clk;

    wb_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o),
        .data_o(data_o), .data_i(data_i), .ack_i(ack_i)
    );

    // Memory responder: combinational ack after wait_target bus cycles
    assign ack_i  = (mem_en && cyc_o && stb_o && (wait_cnt >= wait_target)) || force_ack;
    assign data_i = force_ack ? force_data : mem[addr_o[9:2]];

    always @(posedge clk) begin
        if (cyc_o && !ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_en && !force_ack && cyc_o && stb_o && ack_i && we_o)
            mem[addr_o[9:2]] <= data_o;
    end

    always @(negedge clk) begin
        n_checks++;
        if (cyc_o !== stb_o) begin
            n_fail++;
            $display("FAIL cyc_eq_stb: cyc=%b stb=%b", cyc_o, stb_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, output logic [31:0] rdata, output logic err,
                          output bit ok, output int lat);
        int n;
        ok = 1'b1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready_o && n < 100) begin tick(); n++; end
        if (!req_ready_o) ok = 1'b0;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 100) begin tick(); n++; end
        if (!rsp_valid_o) ok = 1'b0;
        lat = n;
        repeat (stall) tick();
        rdata = rsp_rdata_o;
        err = rsp_err_o;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; bit ok; int lat;
        repeat (2) tick();
        n_checks++;
        if ({req_ready_o, cyc_o, stb_o, rsp_valid_o, rsp_err_o, we_o} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 100000",
                {req_ready_o, cyc_o, stb_o, rsp_valid_o, rsp_err_o, we_o});
        end
        n_checks++;
        if (addr_o !== 32'h0 || data_o !== 32'h0 || rsp_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: addr=%h data=%h rdata=%h want 0", addr_o, data_o, rsp_rdata_o);
        end
        rst_n = 1'b1;
        tick();
        // Mid-bus reset with no responder
        mem_en = 1'b0;
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++;
        if (cyc_o !== 1'b1) begin n_fail++; $display("FAIL midbus_cyc: got %b want 1", cyc_o); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cyc_o, stb_o, rsp_valid_o, req_ready_o} !== 4'b0001) begin
            n_fail++; $display("FAIL async_reset: cyc/stb/rsp_valid/req_ready got %b want 0001",
                {cyc_o, stb_o, rsp_valid_o, req_ready_o});
        end
        #1 rst_n = 1'b1;
        tick();
        mem_en = 1'b1;
        do_txn(1'b1, 32'h44, 32'h5555_AAAA, 0, rd, er, ok, lat);
        n_checks++;
        if (!ok || er !== 1'b0) begin n_fail++; $display("FAIL post_reset_wr: ok=%0d err=%b want ok=1 err=0", ok, er); end
        do_txn(1'b0, 32'h44, 32'h0, 0, rd, er, ok, lat);
        n_checks++;
        if (!ok || rd !== 32'h5555_AAAA) begin n_fail++; $display("FAIL post_reset_rd: got %h want 5555aaaa", rd); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; bit ok; int lat;
        do_txn(1'b1, 32'h10, 32'hCAFE_F00D, 0, rd, er, ok, lat);
        n_checks++;
        if (!ok || er !== 1'b0 || rd !== 32'h0) begin
            n_fail++; $display("FAIL write_rsp: ok=%0d err=%b rdata=%h want 1 0 0", ok, er, rd);
        end
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL write_latency: wait=%0d want 1", lat); end
        do_txn(1'b0, 32'h10, 32'h0, 0, rd, er, ok, lat);
        n_checks++;
        if (!ok || er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL read_rsp: err=%b rdata=%h want 0 cafef00d", er, rd);
        end
        n_checks++;
        if (addr_o !== 32'h10 || we_o !== 1'b0 || cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL bus_hold: addr=%h we=%b cyc=%b want 10 0 0", addr_o, we_o, cyc_o);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] rd; logic er; bit ok; int lat;
        do_txn(1'b1, 32'h20, 32'h1234_5678, 0, rd, er, ok, lat);
        req_we = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hFFFF_0000; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1234_5678 || req_ready_o !== 1'b0 || cyc_o !== 1'b0) begin
                n_fail++; $display("FAIL backpressure[%0d]: valid=%b rdata=%h ready=%b cyc=%b want 1 12345678 0 0",
                    i, rsp_valid_o, rsp_rdata_o, req_ready_o, cyc_o);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #3 req_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: valid=%b ready=%b want 0 1", rsp_valid_o, req_ready_o);
        end
        tick();
        n_checks++;
        if (cyc_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_not_queued: cyc=%b valid=%b want 0 0", cyc_o, rsp_valid_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        mem_en = 1'b0;
        req_we = 1'b0; req_addr = 32'h80; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (cyc_o === 1'b1 && n < 50) begin n++; tick(); end
        n_checks++;
        if (n !== 8) begin n_fail++; $display("FAIL timeout_len: cyc high %0d cycles want 8", n); end
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL timeout_rsp: valid=%b err=%b rdata=%h want 1 1 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        // ack arriving on the last allowed bus cycle
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < 8; k++) tick();
        n_checks++;
        if (cyc_o !== 1'b1) begin n_fail++; $display("FAIL timeout_cycle8: cyc=%b want 1", cyc_o); end
        force_data = 32'hA5A5_A5A5; force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        n_checks++;
        if (cyc_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL late_ack: cyc=%b valid=%b err=%b rdata=%h want 0 1 0 a5a5a5a5",
                cyc_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        mem_en = 1'b1;
    endtask

    task automatic test_spurious_ack();
        force_data = 32'hFFFF_FFFF; force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack: valid=%b ready=%b cyc=%b want 0 1 0", rsp_valid_o, req_ready_o, cyc_o);
        end
        req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        force_data = 32'h1111_1111; force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hCAFE_F00D || cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL resp_ack: valid=%b rdata=%h cyc=%b want 1 cafef00d 0", rsp_valid_o, rsp_rdata_o, cyc_o);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        tick();
        n_checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL no_extra_rsp: valid=%b ready=%b want 0 1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_stress();
        logic [31:0] model [0:15];
        logic [31:0] rd, wd, ad; logic er; bit ok; int lat, idx; logic we;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        for (int t = 0; t < 1000; t++) begin
            idx = int'($urandom_range(15, 0));
            we = 1'($urandom_range(1, 0));
            wd = $urandom;
            ad = 32'h200 + 32'(idx * 4);
            wait_target = int'($urandom_range(3, 0));
            do_txn(we, ad, wd, int'($urandom_range(3, 0)), rd, er, ok, lat);
            n_checks++;
            if (!ok || er !== 1'b0 || rsp_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL stress_rsp[%0d]: ok=%0d err=%b valid_after=%b want 1 0 0", t, ok, er, rsp_valid_o);
            end
            n_checks++;
            if (we) begin
                if (rd !== 32'h0) begin n_fail++; $display("FAIL stress_wr[%0d]: rdata=%h want 0", t, rd); end
                model[idx] = wd;
            end else if (rd !== model[idx]) begin
                n_fail++; $display("FAIL stress_rd[%0d]: addr=%h got %h want %h", t, ad, rd, model[idx]);
            end
        end
        wait_target = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_write_read();
        test_back_pressure();
        test_timeout();
        test_spurious_ack();
        test_stress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
